// File: rtl/apb_master_bridge.sv
// Bridges the core's single-request data-memory bus onto APB4 toward five slaves
// (RAM, GPO, GPI, UART, TIMER). Unmapped addresses and hung slaves complete with err.
//
// state  | meaning
// IDLE   | waiting for transfer; latches request and decodes slave
// SETUP  | APB setup phase, PSEL high, PENABLE low
// ACCESS | APB access phase, waits on selected PREADY or timeout
// ERROR  | unmapped address, one-cycle ready with err
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteEn,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic [3:0]  PSTRB,
  output logic        PENABLE,
  output logic        PSEL0,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PSEL3,
  output logic        PSEL4,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic [31:0] PRDATA4,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3,
  input  logic        PREADY4
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, wdata_q;
  logic              write_q;
  logic [3:0]        be_q;
  logic [2:0]        slave_q;
  logic [4:0]        psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              load;

  logic              dec_hit;
  logic [2:0]        dec_idx;
  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic [2:0]        psel_idx;

  // Each slave owns one 4 KiB window starting at 0x1000_0000.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = 3'd0;
    if (addr[31:16] == 16'h1000 && addr[15:12] <= 4'd4) begin
      dec_hit = 1'b1;
      dec_idx = addr[14:12];
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'h0;
    case (slave_q)
      3'd0: begin sel_ready = PREADY0; sel_rdata = PRDATA0; end
      3'd1: begin sel_ready = PREADY1; sel_rdata = PRDATA1; end
      3'd2: begin sel_ready = PREADY2; sel_rdata = PRDATA2; end
      3'd3: begin sel_ready = PREADY3; sel_rdata = PRDATA3; end
      3'd4: begin sel_ready = PREADY4; sel_rdata = PRDATA4; end
      default: begin sel_ready = 1'b0; sel_rdata = 32'h0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    ready   = 1'b0;
    err     = 1'b0;
    rdata   = 32'h0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          load = 1'b1;
          if (dec_hit) begin
            state_d = SETUP;
            cnt_d   = '0;
          end else begin
            state_d = ERROR;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          ready   = 1'b1;
          rdata   = write_q ? 32'h0 : sel_rdata;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          ready   = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERROR: begin
        ready   = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Selects are registered from the next state so they line up with SETUP/ACCESS.
  always_comb begin
    psel_idx  = (state_q == IDLE) ? dec_idx : slave_q;
    psel_d    = 5'b00000;
    penable_d = 1'b0;
    if (state_d == SETUP || state_d == ACCESS) begin
      psel_d = 5'b00001 << psel_idx;
    end
    if (state_d == ACCESS) begin
      penable_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      write_q   <= 1'b0;
      be_q      <= 4'h0;
      slave_q   <= 3'd0;
      psel_q    <= 5'b00000;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      if (load) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        write_q <= write;
        be_q    <= byteEn;
        slave_q <= dec_idx;
      end
    end
  end

  assign PADDR   = addr_q;
  assign PWDATA  = wdata_q;
  assign PWRITE  = write_q;
  assign PSTRB   = write_q ? be_q : 4'b0000;
  assign PENABLE = penable_q;
  assign PSEL0   = psel_q[0];
  assign PSEL1   = psel_q[1];
  assign PSEL2   = psel_q[2];
  assign PSEL3   = psel_q[3];
  assign PSEL4   = psel_q[4];

`ifndef SYNTHESIS
  a_psel_onehot: assert property (@(posedge clk) $onehot0(psel_q));
  a_penable_sel: assert property (@(posedge clk) penable_q |-> (|psel_q));
`endif

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

Converts the CPU core's single-request data-memory bus (address, write data, byte enables) into APB4 transactions toward five memory-mapped slaves: data RAM, GPO, GPI, UART, TIMER. Sits directly downstream of the datapath's memory-access stage. Returns read data and a completion strobe to the core's control unit, which holds the PC and pipeline while a transfer is outstanding. Unmapped addresses and hung slaves complete with an error instead of stalling the core.

## Interface

**Parameters**
- TIMEOUT, 16: maximum number of ACCESS cycles allowed before a forced abort. Legal range 2..255.

**Ports**
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; low clears all state.
- transfer  in  1  core request. Sampled only in IDLE.
- write  in  1  1 = write, 0 = read. Latched with transfer.
- addr  in  32  byte address, latched with transfer.
- wdata  in  32  write data, already byte-lane aligned, latched with transfer.
- byteEn  in  4  byte-lane enables, latched with transfer.
- rdata  out  32  read data. Valid only while ready=1; 0 at all other times.
- ready  out  1  one-cycle completion strobe.
- err  out  1  qualifies ready; 1 = unmapped address or timeout.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PSTRB  out  4  APB write strobes.
- PENABLE  out  1  APB enable.
- PSEL0..PSEL4  out  1 each  APB selects for RAM, GPO, GPI, UART, TIMER.
- PRDATA0..PRDATA4  in  32 each  slave read data.
- PREADY0..PREADY4  in  1 each  slave ready.

## Operation

**Address map** (decoded from the latched addr):
- 0x1000_0000–0x1000_0FFF → slave 0 (RAM)
- 0x1000_1000–0x1000_1FFF → 1 (GPO)
- 0x1000_2000–0x1000_2FFF → 2 (GPI)
- 0x1000_3000–0x1000_3FFF → 3 (UART)
- 0x1000_4000–0x1000_4FFF → 4 (TIMER)
- anything else is unmapped.

**Request latch:** in IDLE with transfer=1, latch addr, wdata, write, byteEn and the decoded slave index into registers. PADDR, PWDATA and PWRITE are driven from these registers.

**PSTRB:** equals the latched byteEn for writes. Forced to 4'b0000 for reads.

**FSM states:** IDLE, SETUP, ACCESS, ERROR.
- IDLE
  - transfer=1 and address mapped → SETUP.
  - transfer=1 and address unmapped → ERROR.
  - otherwise stay in IDLE.
- SETUP: PSELn=1 for the decoded slave only, PENABLE=0. Always → ACCESS.
- ACCESS: PSELn=1 and PENABLE=1.
  - Selected PREADY=1 → drive ready=1, err=0, rdata = selected PRDATA (reads) or 0 (writes); → IDLE.
  - Otherwise increment the timeout counter.
- ERROR: no PSEL asserted, ready=1, err=1, rdata=0. → IDLE.

**Timeout:**
- Counter is cleared on entry to SETUP. Width is clog2(TIMEOUT+1).
- In ACCESS, if the selected PREADY=0 and the counter = TIMEOUT-1: ready=1, err=1, rdata=0; → IDLE. PSEL and PENABLE drop in the next cycle.

**Request handling while busy:**
- transfer is ignored outside IDLE. The latched request is immune to input changes mid-transfer.
- PREADY and PRDATA of non-selected slaves are ignored.
- The core must deassert transfer in the cycle after ready. If transfer is still high in that IDLE cycle, a new transaction starts (back-to-back is legal).

## Timing

**Reset values:** while reset=0 at a clock edge, the next state is IDLE and every output is 0: PSEL0..4, PENABLE, PADDR, PWDATA, PWRITE, PSTRB, ready, err, rdata. This includes reset asserted during SETUP or ACCESS: the transfer is dropped and no ready is issued.

**Latency:**
- ready, err and rdata are combinational from state and selected PREADY/PRDATA.
- PSEL, PENABLE and the P* address/data outputs are registered (state-derived).
- Mapped access, zero-wait slave: transfer sampled at edge T; SETUP in cycle T+1; ACCESS with ready=1 in cycle T+2. Three cycles from request to completion.
- Each slave wait cycle adds 1.
- Unmapped access: ready/err in cycle T+1.
- Timeout: ready/err in the TIMEOUT-th ACCESS cycle, i.e. cycle T+1+TIMEOUT.

**APB4 rules held:**
- PADDR, PWRITE, PWDATA, PSTRB and PSELn are stable from SETUP through the last ACCESS cycle.
- PENABLE is never high without a PSEL.
- At most one PSEL is high at a time.

## Test plan

- **Zero-wait RAM write:** write=1, addr=0x1000_0010, wdata=0xA5A5_1234, byteEn=4'b0011, PREADY0 tied high.
  - Required: PSEL0 high for cycles T+1..T+2, PENABLE high at T+2, PSTRB=4'b0011, ready=1 and err=0 at T+2, IDLE at T+3.
- **Wait-state GPI read:** addr=0x1000_2000, PREADY2 low for 3 ACCESS cycles, PRDATA2=0x0000_00FF.
  - Required: ready at T+5, rdata=0x0000_00FF, PSTRB=0, no other PSEL ever high.
- **Unmapped address:** addr=0x2000_0000, read.
  - Required: no PSEL ever high, ready=1, err=1, rdata=0 at T+1.
- **Timeout:** TIMEOUT=4, addr=0x1000_3004, PREADY3 held low.
  - Required: ready=1, err=1 at T+5; PSEL3 low at T+6.
- **Back-to-back and ignored inputs:** transfer held high across completion; addr/wdata changed during ACCESS.
  - Required: first transaction uses the originally latched values; second enters SETUP in the cycle after IDLE resample.
- **Reset mid-ACCESS:** reset=0 for one edge during a stalled TIMER access.
  - Required: all outputs 0 the next cycle, no ready pulse, a fresh request then completes normally.
